// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter:
// FSM state encoding, BCD digit width and the digit-count check.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int BCD_DIGIT_W = 4;

   // True when DIGITS decimal digits can hold 2**bin_w-1.
   function automatic bit digits_ok(input int bin_w, input int digits);
      longint pow10;
      longint max_bin;
      pow10 = 1;
      for (int i = 0; i < digits; i++) begin
         pow10 = pow10 * 10;
      end
      max_bin = (longint'(1) << bin_w) - 1;
      return pow10 > max_bin;
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// Double-dabble nibble adjust: adds 3 to a BCD digit >= 5.
// Ports: nib_i (4-bit digit in), nib_o (adjusted digit out).
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] nib_i,
   output logic [BCD_DIGIT_W-1:0] nib_o
);

   // nib_i <= 9 in normal operation, so +3 stays within 4 bits.
   assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary to packed BCD converter, one bit per clock.
// Ports: clk, rst_n (sync, active-low), start/bin_in (request),
//        busy, done (1-cycle pulse), bcd_out (held result, units in [3:0]).
module bin_to_bcd_serial
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_WIDTH-1:0]          bin_in,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + BIN_WIDTH;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   if (BIN_WIDTH < 4 || BIN_WIDTH > 16) begin : g_bad_width
      $error("bin_to_bcd_serial: BIN_WIDTH must be 4..16");
   end

   if (!digits_ok(BIN_WIDTH, DIGITS)) begin : g_bad_digits
      $error("bin_to_bcd_serial: DIGITS too small for BIN_WIDTH");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;

   logic [BCD_W-1:0]  adj;
   logic [SR_W-1:0]   sr_adj;
   logic [SR_W-1:0]   sr_shl;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i (sr_q[BIN_WIDTH+BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .nib_o (adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
   end

   // Adjust every digit, then shift the whole register left.
   assign sr_adj = {adj, sr_q[BIN_WIDTH-1:0]};
   assign sr_shl = sr_adj << 1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               sr_d    = {{BCD_W{1'b0}}, bin_in};
               cnt_d   = CNT_W'(BIN_WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = sr_shl;
            cnt_d = cnt_q - CNT_W'(1);
            // Last shift: publish the BCD field in the same edge.
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = sr_shl[SR_W-1 -: BCD_W];
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy    = (state_q == SHIFT);
   assign done    = (state_q == DONE);
   assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial (8-bit and 10-bit builds).
// Directed vector table, reference sweep, and multi-cycle corner sequences.
module tb_bin_to_bcd_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  bin_in;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;

   logic        start10;
   logic [9:0]  bin10;
   logic        busy10;
   logic        done10;
   logic [15:0] bcd10;

   int checks;
   int failures;
   int excl_err;

   bin_to_bcd_serial #(.BIN_WIDTH(8), .DIGITS(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
   );

   bin_to_bcd_serial #(.BIN_WIDTH(10), .DIGITS(4)) dut10 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start10),
      .bin_in  (bin10),
      .busy    (busy10),
      .done    (done10),
      .bcd_out (bcd10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((busy && done) || (busy10 && done10)) excl_err++;
   end

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Accept v at the next edge, then wait (bounded) for done.
   task automatic conv(input logic [7:0] v, output logic [11:0] res,
                       output int lat, output int busy_n);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk); #1;
      start  = 1'b0;
      bin_in = ~v;
      lat    = 0;
      busy_n = 0;
      while (!done && lat < 30) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      res = bcd_out;
   endtask

   initial begin
      logic [11:0] res;
      logic [11:0] hold;
      int lat, bn, dn, t1, t2, flick;
      logic [11:0] v1, v2;

      checks   = 0;
      failures = 0;
      excl_err = 0;

      vecs[0]  = '{8'd0,   12'h000};
      vecs[1]  = '{8'd255, 12'h255};
      vecs[2]  = '{8'd99,  12'h099};
      vecs[3]  = '{8'd100, 12'h100};
      vecs[4]  = '{8'd1,   12'h001};
      vecs[5]  = '{8'd9,   12'h009};
      vecs[6]  = '{8'd10,  12'h010};
      vecs[7]  = '{8'd42,  12'h042};
      vecs[8]  = '{8'd128, 12'h128};
      vecs[9]  = '{8'd200, 12'h200};
      vecs[10] = '{8'd63,  12'h063};
      vecs[11] = '{8'd199, 12'h199};

      rst_n   = 1'b0;
      start   = 1'b0;
      bin_in  = 8'd0;
      start10 = 1'b0;
      bin10   = 10'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_bcd", 32'(bcd_out), 0);
      chk("reset_bcd10", 32'(bcd10), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero input: latency and busy length.
      conv(8'd0, res, lat, bn);
      chk("zero_result", 32'(res), 32'h000);
      chk("zero_latency", lat, 8);
      chk("zero_busy_cycles", bn, 8);

      for (int i = 0; i < 12; i++) begin
         conv(vecs[i].bin, res, lat, bn);
         chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_latency", i), lat, 8);
      end

      for (int v = 0; v < 256; v++) begin
         conv(8'(v), res, lat, bn);
         chk($sformatf("sweep_%0d", v), 32'(res), 32'(ref_bcd(v)));
      end
      @(posedge clk); #1;

      // Back-to-back with start held and bin_in changed mid-busy.
      dn = 0; t1 = -1; t2 = -1; v1 = '0; v2 = '0;
      start  = 1'b1;
      bin_in = 8'd42;
      for (int t = 0; t <= 18; t++) begin
         if (t == 3) bin_in = 8'd7;
         @(posedge clk); #1;
         if (done) begin
            dn++;
            if (dn == 1) begin t1 = t; v1 = bcd_out; end
            if (dn == 2) begin t2 = t; v2 = bcd_out; end
         end
      end
      start = 1'b0;
      chk("b2b_done_count", dn, 2);
      chk("b2b_first_t", t1, 8);
      chk("b2b_first_val", 32'(v1), 32'h042);
      chk("b2b_second_t", t2, 17);
      chk("b2b_second_val", 32'(v2), 32'h007);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_third_done", 32'(done), 1);
      @(posedge clk); #1;

      // Reset on the 4th edge of a conversion of 200.
      start  = 1'b1;
      bin_in = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_bcd", 32'(bcd_out), 0);
      dn = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      chk("midrst_no_done", dn, 0);
      conv(8'd200, res, lat, bn);
      chk("midrst_after", 32'(res), 32'h200);
      @(posedge clk); #1;

      // start pulsed during SHIFT: ignored; no flicker.
      hold  = bcd_out;
      chk("pulse_pre_hold", 32'(hold), 32'h200);
      dn = 0; t1 = -1; v1 = '0; flick = 0;
      start  = 1'b1;
      bin_in = 8'd55;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         start  = (t == 3);
         bin_in = (t == 3) ? 8'd99 : 8'd0;
         @(posedge clk); #1;
         if (done) begin
            dn++;
            t1   = t;
            v1   = bcd_out;
            hold = bcd_out;
         end else if (bcd_out !== hold) begin
            flick++;
         end
      end
      start = 1'b0;
      chk("pulse_done_count", dn, 1);
      chk("pulse_done_t", t1, 8);
      chk("pulse_val", 32'(v1), 32'h055);
      chk("pulse_no_flicker", flick, 0);

      // 10-bit build, max input.
      start10 = 1'b1;
      bin10   = 10'd1023;
      @(posedge clk); #1;
      start10 = 1'b0;
      bin10   = 10'd0;
      lat     = 0;
      while (!done10 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w10_result", 32'(bcd10), 32'h1023);
      chk("w10_latency", lat, 10);

      chk("busy_done_exclusive", excl_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
